// File: rtl/keccak_globals.sv
// rtl/keccak_globals.sv - shared Keccak types, sponge FSM encoding and lane index helpers
// Contents:
//   k_lane / k_plane / k_state : 64-bit lane, 5-lane plane, 25-lane (1600-bit) state
//                                lane i lives at state[y][x], x = i%5, y = i/5,
//                                i.e. bits [64*i +: 64] of the packed state
//   sponge_fsm_e               : sponge controller states
//   RATE_MAX                   : largest supported rate in lanes (SHAKE128)
//   lane_x / lane_y            : lane index -> x / y coordinates
package keccak_globals;

  typedef logic [63:0]  k_lane;
  typedef k_lane [4:0]  k_plane;
  typedef k_plane [4:0] k_state;

  localparam int RATE_MAX = 21;

  typedef enum logic [1:0] {
    SP_ABSORB  = 2'd0,
    SP_PERM    = 2'd1,
    SP_SQUEEZE = 2'd2,
    SP_FLUSH   = 2'd3
  } sponge_fsm_e;

  function automatic logic [2:0] lane_x(input logic [4:0] idx);
    return 3'(idx % 5'd5);
  endfunction

  function automatic logic [2:0] lane_y(input logic [4:0] idx);
    return 3'(idx / 5'd5);
  endfunction

endpackage

// File: rtl/keccak_lane_sel.sv
// rtl/keccak_lane_sel.sv - combinational 25:1 lane read mux over a Keccak state
// Ports:
//   state_i : k_state  full 1600-bit state
//   idx_i   : [4:0]    lane index 0..24 (indices above 24 read as zero)
//   lane_o  : k_lane   selected lane
module keccak_lane_sel
  import keccak_globals::*;
(
  input  k_state     state_i,
  input  logic [4:0] idx_i,
  output k_lane      lane_o
);

  always_comb begin
    lane_o = '0;
    if (idx_i < 5'd25) begin
      lane_o = state_i[lane_y(idx_i)][lane_x(idx_i)];
    end
  end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// rtl/keccak_sponge_ctrl.sv - Keccak sponge front-end: absorb lanes, run permutation, squeeze lanes
// Ports:
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   clear_i                : synchronous abort / new message (highest priority)
//   rate_lanes_i[4:0]      : rate in lanes, latched on the first beat of a message
//                            (0 or > RATE_MAX saturates to RATE_MAX)
//   in_valid_i/in_ready_o  : absorb handshake; in_data_i[63:0] lane, in_last_i end of message
//   perm_start_o           : one-cycle pulse starting the core on perm_state_o[1599:0]
//   perm_done_i            : one-cycle pulse, perm_state_i[1599:0] valid
//   out_valid_o/out_ready_i: squeeze handshake; out_data_o[63:0] lane
//   busy_o                 : permutation in flight (PERM or FLUSH)
//   perm_cnt_o[31:0]       : count of perm_start_o pulses, only with KECCAK_SPONGE_STATS_EN
// Build option: define KECCAK_SPONGE_STATS_EN to add the permutation counter.
module keccak_sponge_ctrl
  import keccak_globals::*;
(
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clear_i,
  input  logic [4:0]    rate_lanes_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [63:0]   in_data_i,
  input  logic          in_last_i,
  output logic          perm_start_o,
  output logic [1599:0] perm_state_o,
  input  logic          perm_done_i,
  input  logic [1599:0] perm_state_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [63:0]   out_data_o,
  output logic          busy_o
`ifdef KECCAK_SPONGE_STATS_EN
  ,
  output logic [31:0]   perm_cnt_o
`endif
);

  sponge_fsm_e fsm_q, fsm_d;
  k_state      state_q;
  logic [4:0]  lane_cnt_q;
  logic [4:0]  rate_q;
  logic        final_q;
  logic        in_msg_q;    // a message has started and its last lane is not yet absorbed
  logic        start_q;

  k_lane       rd_lane;
  logic [4:0]  rate_sat;
  logic [4:0]  rate_eff;
  logic        in_hs;
  logic        out_hs;
  logic        wipe;

  keccak_lane_sel u_lane_sel (
    .state_i (state_q),
    .idx_i   (lane_cnt_q),
    .lane_o  (rd_lane)
  );

  // The first beat of a message uses the live rate input; later beats use the latched copy.
  assign rate_sat = (rate_lanes_i == 5'd0 || rate_lanes_i > 5'(RATE_MAX)) ? 5'(RATE_MAX) : rate_lanes_i;
  assign rate_eff = in_msg_q ? rate_q : rate_sat;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fsm_q <= SP_ABSORB;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    busy_o       = 1'b0;
    out_data_o   = '0;
    perm_start_o = start_q;
    in_hs        = 1'b0;
    out_hs       = 1'b0;
    case (fsm_q)
      SP_ABSORB: begin
        in_ready_o = 1'b1;
        in_hs      = in_valid_i && !clear_i;
        if (in_hs && (lane_cnt_q == rate_eff - 5'd1 || in_last_i)) begin
          fsm_d = SP_PERM;
        end
      end
      SP_PERM: begin
        busy_o = 1'b1;
        // A clear coinciding with done has nothing left to wait for.
        if (clear_i) begin
          fsm_d = perm_done_i ? SP_ABSORB : SP_FLUSH;
        end else if (perm_done_i) begin
          fsm_d = final_q ? SP_SQUEEZE : SP_ABSORB;
        end
      end
      SP_SQUEEZE: begin
        out_valid_o = 1'b1;
        out_data_o  = rd_lane;
        out_hs      = out_ready_i && !clear_i;
        if (clear_i) begin
          fsm_d = SP_ABSORB;
        end else if (out_hs && lane_cnt_q == rate_q - 5'd1) begin
          fsm_d = SP_PERM;
        end
      end
      SP_FLUSH: begin
        busy_o = 1'b1;
        if (perm_done_i) begin
          fsm_d = SP_ABSORB;
        end
      end
      default: fsm_d = SP_ABSORB;
    endcase
    wipe = (fsm_d == SP_ABSORB) && (clear_i || fsm_q == SP_FLUSH);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= '0;
      lane_cnt_q <= '0;
      rate_q     <= 5'(RATE_MAX);
      final_q    <= 1'b0;
      in_msg_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q <= (fsm_q == SP_ABSORB || fsm_q == SP_SQUEEZE) && fsm_d == SP_PERM;
      if (wipe) begin
        state_q    <= '0;
        lane_cnt_q <= '0;
        final_q    <= 1'b0;
        in_msg_q   <= 1'b0;
      end else if (in_hs) begin
        state_q[lane_y(lane_cnt_q)][lane_x(lane_cnt_q)] <= rd_lane ^ in_data_i;
        lane_cnt_q <= lane_cnt_q + 5'd1;
        in_msg_q   <= !in_last_i;
        if (!in_msg_q) begin
          rate_q <= rate_sat;
        end
        if (fsm_d == SP_PERM) begin
          final_q <= in_last_i;
        end
      end else if (fsm_q == SP_PERM && perm_done_i) begin
        state_q    <= perm_state_i;
        lane_cnt_q <= '0;
      end else if (out_hs) begin
        lane_cnt_q <= lane_cnt_q + 5'd1;
      end
    end
  end

  assign perm_state_o = state_q;

`ifdef KECCAK_SPONGE_STATS_EN
  logic [31:0] perm_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perm_cnt_q <= '0;
    end else if (clear_i) begin
      perm_cnt_q <= '0;
    end else if (perm_start_o) begin
      perm_cnt_q <= perm_cnt_q + 32'd1;
    end
  end

  assign perm_cnt_o = perm_cnt_q;
`endif

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// tb/tb_keccak_sponge_ctrl.sv - directed self-checking bench for keccak_sponge_ctrl
module tb_keccak_sponge_ctrl;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [4:0]    rate_lanes_i = 5'd0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [63:0]   in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic          perm_start_o;
  logic [1599:0] perm_state_o;
  logic          perm_done_i = 1'b0;
  logic [1599:0] perm_state_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [63:0]   out_data_o;
  logic          busy_o;
`ifdef KECCAK_SPONGE_STATS_EN
  logic [31:0]   perm_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  keccak_sponge_ctrl dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clear_i      (clear_i),
    .rate_lanes_i (rate_lanes_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .perm_start_o (perm_start_o),
    .perm_state_o (perm_state_o),
    .perm_done_i  (perm_done_i),
    .perm_state_i (perm_state_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .busy_o       (busy_o)
`ifdef KECCAK_SPONGE_STATS_EN
    ,
    .perm_cnt_o   (perm_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lane_of(input logic [1599:0] v, input int i);
    return v[64*i +: 64];
  endfunction

  task automatic chk_state(input string tag, input logic [1599:0] exp);
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("%s_lane%0d", tag, i), lane_of(perm_state_o, i), lane_of(exp, i));
    end
  endtask

  // Absorb one lane; starts and ends on a falling edge.
  task automatic send(input logic [63:0] d, input logic last);
    int n;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    n = 0;
    while (!in_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) chk("send_timeout", 64'(n), 64'd0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  // Permutation core model: done pulse 4 cycles after the start pulse.
  task automatic respond(input logic [1599:0] st);
    repeat (3) @(negedge clk_i);
    perm_done_i  = 1'b1;
    perm_state_i = st;
    @(negedge clk_i);
    perm_done_i  = 1'b0;
  endtask

  logic [1599:0] exp_v;
  logic [1599:0] inv_v;
  logic [1599:0] rsp_v;
  int idx;

  initial begin
    for (int i = 0; i < 25; i++) inv_v[64*i +: 64] = ~64'(i);

    // Reset values
    repeat (2) @(negedge clk_i);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_start", 64'(perm_start_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_out_data", out_data_o, 64'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // SHA3-256, rate 17
    rate_lanes_i = 5'd17;
    for (int i = 0; i < 17; i++) send(64'(i + 1), i == 16);
    chk("s256_start", 64'(perm_start_o), 64'd1);
    chk("s256_busy", 64'(busy_o), 64'd1);
    exp_v = '0;
    for (int i = 0; i < 17; i++) exp_v[64*i +: 64] = 64'(i + 1);
    chk_state("s256_state", exp_v);
    @(negedge clk_i);
    chk("s256_start_once", 64'(perm_start_o), 64'd0);
    respond(inv_v);
    out_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk("s256_sq_valid", 64'(out_valid_o), 64'd1);
      chk("s256_sq_data", out_data_o, ~64'(i));
      @(negedge clk_i);
    end
    chk("s256_restart", 64'(perm_start_o), 64'd1);
    out_ready_i = 1'b0;
    respond(inv_v);
    out_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("s256_sq2_data", out_data_o, ~64'(i));
      @(negedge clk_i);
    end
    out_ready_i = 1'b0;

    // Asynchronous reset in the middle of SQUEEZE
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready_o), 64'd1);
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk_state("arst_state", '0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Short message, rate 0 saturates to 21
    rate_lanes_i = 5'd0;
    send(64'hA, 1'b0);
    send(64'hB, 1'b0);
    chk("short_no_start", 64'(perm_start_o), 64'd0);
    send(64'hC, 1'b1);
    chk("short_start", 64'(perm_start_o), 64'd1);
    exp_v = '0;
    exp_v[63:0] = 64'hA;
    exp_v[127:64] = 64'hB;
    exp_v[191:128] = 64'hC;
    chk_state("short_state", exp_v);
    for (int i = 0; i < 25; i++) rsp_v[64*i +: 64] = 64'hAB00 + 64'(i);
    respond(rsp_v);
    chk("short_sq_data", out_data_o, 64'hAB00);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("clr_in_ready", 64'(in_ready_o), 64'd1);
    chk("clr_out_valid", 64'(out_valid_o), 64'd0);
    chk_state("clr_state", '0);

    // Multi-block, rate 9; rate change in block 2 must be ignored
    rate_lanes_i = 5'd9;
    for (int i = 0; i < 9; i++) send(64'd1, 1'b0);
    chk("mb1_start", 64'(perm_start_o), 64'd1);
    chk("mb1_in_ready", 64'(in_ready_o), 64'd0);
    for (int i = 0; i < 25; i++) rsp_v[64*i +: 64] = 64'hF0;
    respond(rsp_v);
    chk("mb1_in_ready_after", 64'(in_ready_o), 64'd1);
    chk("mb1_out_valid_after", 64'(out_valid_o), 64'd0);
    rate_lanes_i = 5'd5;
    for (int i = 0; i < 9; i++) begin
      send(64'h0F, i == 8);
      if (i < 8) chk("mb2_no_start", 64'(perm_start_o), 64'd0);
    end
    chk("mb2_start", 64'(perm_start_o), 64'd1);
    exp_v = rsp_v;
    for (int i = 0; i < 9; i++) exp_v[64*i +: 64] = 64'hFF;
    chk_state("mb2_state", exp_v);

    // Squeeze with 0101... backpressure
    for (int i = 0; i < 25; i++) rsp_v[64*i +: 64] = 64'h1111 * 64'(i + 1);
    respond(rsp_v);
    idx = 0;
    for (int k = 0; k < 40 && idx < 9; k++) begin
      out_ready_i = (k % 2 == 1);
      chk("bp_valid", 64'(out_valid_o), 64'd1);
      chk("bp_data", out_data_o, 64'h1111 * 64'(idx + 1));
      if (out_ready_i) idx++;
      @(negedge clk_i);
    end
    out_ready_i = 1'b0;
    chk("bp_count", 64'(idx), 64'd9);
    chk("bp_restart", 64'(perm_start_o), 64'd1);

    // clear_i during PERM -> FLUSH until done, then zero state
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("fl_busy", 64'(busy_o), 64'd1);
    chk("fl_in_ready", 64'(in_ready_o), 64'd0);
`ifdef KECCAK_SPONGE_STATS_EN
    chk("fl_perm_cnt", 64'(perm_cnt_o), 64'd0);
`endif
    repeat (3) @(negedge clk_i);
    chk("fl_in_ready_wait", 64'(in_ready_o), 64'd0);
    chk("fl_no_start", 64'(perm_start_o), 64'd0);
    perm_done_i  = 1'b1;
    perm_state_i = '1;
    @(negedge clk_i);
    perm_done_i  = 1'b0;
    chk("fl_in_ready_done", 64'(in_ready_o), 64'd1);
    chk("fl_busy_done", 64'(busy_o), 64'd0);
    chk("fl_no_start_done", 64'(perm_start_o), 64'd0);
    chk_state("fl_state", '0);
    rate_lanes_i = 5'd21;
    send(64'h55, 1'b1);
    chk("post_start", 64'(perm_start_o), 64'd1);
    @(negedge clk_i);
`ifdef KECCAK_SPONGE_STATS_EN
    chk("post_perm_cnt", 64'(perm_cnt_o), 64'd1);
`endif
    respond(rsp_v);
    chk("post_sq_data", out_data_o, 64'h1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
